// File: rtl/timer_mmio_if.sv
// Data-memory bus slice seen by the machine timer: core drives address/data/byte
// enables, the timer returns registered read data and a hit flag.
interface timer_mmio_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [3:0]      we;
   logic [XLEN-1:0] rdata;
   logic            hit;

   modport master (output addr, output wdata, output we, input rdata, input hit);
   modport slave  (input addr, input wdata, input we, output rdata, output hit);
endinterface

// File: rtl/timer_mmio.sv
// RISC-V machine timer (mtime/mtimecmp) with prescaler, control register,
// tear-free 64-bit read shadow and a level timer interrupt.
module timer_mmio #(
   parameter int          XLEN         = 32,
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic         clk,
   input  logic         rst,
   timer_mmio_if.slave  bus,
   output logic         int_timer
);

   logic [63:0]     mtime;
   logic [63:0]     mtimecmp;
   logic [31:0]     shadow_hi;
   logic            en;
   logic            ie;
   logic [7:0]      prescale;
   logic [7:0]      psc_cnt;

   logic            hit;
   logic [2:0]      off;
   logic            wr;
   logic            tick;
   logic [XLEN-1:0] rd_sel;
   logic            en_new;
   logic            ie_new;
   logic [7:0]      prescale_new;

   function automatic logic [31:0] merge(input logic [31:0] old_val,
                                         input logic [31:0] new_val,
                                         input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   always_comb begin
      hit  = (bus.addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
      off  = bus.addr[4:2];
      wr   = hit && (bus.we != 4'b0000);
      tick = en && (psc_cnt == prescale);

      en_new       = bus.we[0] ? bus.wdata[0]    : en;
      ie_new       = bus.we[0] ? bus.wdata[1]    : ie;
      prescale_new = bus.we[1] ? bus.wdata[15:8] : prescale;

      // MTIME_HI deliberately returns the shadow captured by the last LO read
      rd_sel = '0;
      case (off)
         3'd0:    rd_sel = mtime[31:0];
         3'd1:    rd_sel = shadow_hi;
         3'd2:    rd_sel = mtimecmp[31:0];
         3'd3:    rd_sel = mtimecmp[63:32];
         3'd4:    rd_sel = {16'h0000, prescale, 6'b000000, ie, en};
         default: rd_sel = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime     <= '0;
         mtimecmp  <= MTIMECMP_RST;
         shadow_hi <= '0;
         en        <= 1'b0;
         ie        <= 1'b0;
         prescale  <= '0;
         psc_cnt   <= '0;
         bus.rdata <= '0;
         bus.hit   <= 1'b0;
         int_timer <= 1'b0;
      end else begin
         if (en) psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
         if (tick) mtime <= mtime + 64'd1;

         // a bus write to mtime overrides the tick of the same cycle entirely
         if (wr) begin
            case (off)
               3'd0: mtime <= {mtime[63:32], merge(mtime[31:0], bus.wdata, bus.we)};
               3'd1: mtime <= {merge(mtime[63:32], bus.wdata, bus.we), mtime[31:0]};
               3'd2: mtimecmp[31:0]  <= merge(mtimecmp[31:0], bus.wdata, bus.we);
               3'd3: mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.wdata, bus.we);
               3'd4: begin
                  en       <= en_new;
                  ie       <= ie_new;
                  prescale <= prescale_new;
                  psc_cnt  <= '0;
               end
               default: ;
            endcase
         end

         if (hit && (off == 3'd0) && (bus.we == 4'b0000)) shadow_hi <= mtime[63:32];

         bus.rdata <= hit ? rd_sel : '0;
         bus.hit   <= hit;
         int_timer <= ie && (mtime >= mtimecmp);
      end
   end

endmodule

// File: tb/tb_timer_mmio.sv
// Randomized and directed scoreboard bench for timer_mmio against a cycle-level
// behavioural model of the timer registers.
module tb_timer_mmio;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst;
   logic int_timer;

   timer_mmio_if #(.XLEN(32)) bus ();

   timer_mmio #(
      .XLEN(32),
      .BASE_ADDR(BASE),
      .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .int_timer(int_timer)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hit;
      logic [31:0] rdata;
      logic        irq;
      bit          cr;
      logic [31:0] vr;
      bit          ci;
      logic        vi;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;

   // reference model state
   logic [63:0] m_time;
   logic [63:0] m_cmp;
   logic [31:0] m_shadow;
   logic        m_en;
   logic        m_ie;
   int unsigned m_ps;
   int unsigned m_cnt;

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w,
                                       input logic [3:0] lanes);
      for (int i = 0; i < 4; i++) if (lanes[i]) o[8*i +: 8] = w[8*i +: 8];
      return o;
   endfunction

   task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input logic r, input bit cr = 0, input logic [31:0] vr = 32'h0,
                        input bit ci = 0, input logic vi = 1'b0);
      exp_t        e;
      logic        h;
      int unsigned o;
      logic [31:0] rd;
      logic [31:0] c;
      logic [63:0] n_time;
      int unsigned n_cnt;
      bit          tk;
      @(negedge clk);
      bus.addr  = a;
      bus.wdata = wd;
      bus.we    = we;
      rst       = r;
      h = (a[31:5] == BASE[31:5]);
      o = a[4:2];
      case (o)
         0:       rd = m_time[31:0];
         1:       rd = m_shadow;
         2:       rd = m_cmp[31:0];
         3:       rd = m_cmp[63:32];
         4:       rd = {16'h0, m_ps[7:0], 6'h0, m_ie, m_en};
         default: rd = 32'h0;
      endcase
      e.cr = cr; e.vr = vr; e.ci = ci; e.vi = vi;
      if (r) begin
         e.hit = 1'b0; e.rdata = 32'h0; e.irq = 1'b0;
      end else begin
         e.hit = h; e.rdata = h ? rd : 32'h0; e.irq = m_ie && (m_time >= m_cmp);
      end
      sbq.push_back(e);
      if (r) begin
         m_time = 64'h0; m_cmp = '1; m_shadow = 32'h0;
         m_en = 1'b0; m_ie = 1'b0; m_ps = 0; m_cnt = 0;
      end else begin
         tk     = m_en && (m_cnt == m_ps);
         n_time = tk ? m_time + 64'd1 : m_time;
         n_cnt  = m_en ? (tk ? 0 : m_cnt + 1) : m_cnt;
         if (h && o == 0 && we == 4'h0) m_shadow = m_time[63:32];
         if (h && we != 4'h0) begin
            case (o)
               0: n_time = {m_time[63:32], mrg(m_time[31:0], wd, we)};
               1: n_time = {mrg(m_time[63:32], wd, we), m_time[31:0]};
               2: m_cmp[31:0]  = mrg(m_cmp[31:0], wd, we);
               3: m_cmp[63:32] = mrg(m_cmp[63:32], wd, we);
               4: begin
                  c = mrg({16'h0, m_ps[7:0], 6'h0, m_ie, m_en}, wd, we);
                  m_en = c[0]; m_ie = c[1]; m_ps = c[15:8]; n_cnt = 0;
               end
               default: ;
            endcase
         end
         m_time = n_time;
         m_cnt  = n_cnt;
      end
   endtask

   function automatic logic [31:0] ra(input int off);
      return BASE + 32'(off * 4);
   endfunction

   task automatic wr(input int off, input logic [31:0] wd, input logic [3:0] we = 4'hF,
                     input bit ci = 0, input logic vi = 1'b0);
      cycle(ra(off), wd, we, 1'b0, 0, 32'h0, ci, vi);
   endtask

   task automatic rd_chk(input int off, input logic [31:0] v);
      cycle(ra(off), 32'h0, 4'h0, 1'b0, 1, v);
   endtask

   task automatic idle(input int n, input bit ci = 0, input logic vi = 1'b0);
      for (int i = 0; i < n; i++) cycle(32'h0000_1000, 32'h0, 4'h0, 1'b0, 0, 32'h0, ci, vi);
   endtask

   task automatic reset_dut();
      cycle(32'h0, 32'h0, 4'h0, 1'b1);
   endtask

   // monitor: pops one expectation per clock edge and compares
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (bus.hit !== e.hit || bus.rdata !== e.rdata || int_timer !== e.irq) begin
               miscompares++;
               $display("FAIL model t=%0t hit=%b/%b rdata=%h/%h irq=%b/%b (got/exp)", $time,
                        bus.hit, e.hit, bus.rdata, e.rdata, int_timer, e.irq);
            end
            if (e.cr && bus.rdata !== e.vr) begin
               miscompares++;
               $display("FAIL directed_rdata t=%0t got=%h exp=%h", $time, bus.rdata, e.vr);
            end
            if (e.ci && int_timer !== e.vi) begin
               miscompares++;
               $display("FAIL directed_irq t=%0t got=%b exp=%b", $time, int_timer, e.vi);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, wd;
      logic [3:0]  we;
      logic        r;
      int unsigned o;
      bus.addr = '0; bus.wdata = '0; bus.we = '0; rst = 1'b1;
      m_time = '0; m_cmp = '1; m_shadow = '0; m_en = 0; m_ie = 0; m_ps = 0; m_cnt = 0;

      // reset and idle, then read mtimecmp reset value
      reset_dut();
      for (int i = 0; i < 10; i++) cycle(32'h0, 32'h0, 4'h0, 1'b0, 1, 32'h0, 1, 1'b0);
      rd_chk(2, 32'hFFFF_FFFF);

      // prescale 3: ten increments over forty cycles
      reset_dut();
      wr(4, 32'h0000_0301);
      idle(40);
      rd_chk(0, 32'd10);
      rd_chk(4, 32'h0000_0301);

      // low-word wrap with tear-free high read
      reset_dut();
      wr(4, 32'h0000_0001);
      wr(1, 32'h0);
      wr(0, 32'hFFFF_FFFF);
      rd_chk(0, 32'hFFFF_FFFF);
      rd_chk(1, 32'h0);
      rd_chk(0, 32'h1);
      rd_chk(1, 32'h1);

      // interrupt rise and clear
      reset_dut();
      wr(3, 32'h0);
      wr(2, 32'd20);
      wr(4, 32'h0000_0003, 4'hF, 1, 1'b0);
      idle(20, 1, 1'b0);
      idle(1, 1, 1'b1);
      idle(3, 1, 1'b1);
      wr(2, 32'd100, 4'hF, 1, 1'b1);
      idle(3, 1, 1'b0);

      // byte lane write and out-of-window access
      reset_dut();
      wr(2, 32'h0000_AB00, 4'b0010);
      rd_chk(2, 32'hFFFF_ABFF);
      cycle(BASE + 32'h20, 32'h0, 4'hF, 1'b0, 1, 32'h0);
      cycle(BASE + 32'h28, 32'h0, 4'h0, 1'b0, 1, 32'h0);
      rd_chk(2, 32'hFFFF_ABFF);
      rd_chk(6, 32'h0);

      // write beats tick, then reset with a write pending
      reset_dut();
      wr(4, 32'h0000_0001);
      idle(3);
      wr(0, 32'd5);
      rd_chk(0, 32'd5);
      cycle(ra(4), 32'h0000_0003, 4'hF, 1'b1);
      rd_chk(2, 32'hFFFF_FFFF);
      rd_chk(0, 32'h0);
      rd_chk(4, 32'h0);

      // randomized traffic
      reset_dut();
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 99) == 0);
         o = $urandom_range(0, 7);
         a = BASE | (o << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) a = $urandom;
         we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
         wd = $urandom;
         if (o == 4) wd[15:8] = 8'($urandom_range(0, 3));
         if ((o == 1 || o == 3) && $urandom_range(0, 1)) wd = 32'h0;
         if (o == 2 && $urandom_range(0, 1)) wd = wd & 32'h0000_01FF;
         cycle(a, wd, we, r);
      end

      idle(2);
      repeat (3) @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL drain left=%0d exp=0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
